store_buffer_queue: RTL and testbench

Committed-store buffer in the MEM stage. It holds speculative 32-bit stores until the ROB commits them, drains committed stores in order to the data cache, and forwards store data to younger loads. Stores enter from EXE/MEM and receive an entry index that travels to the ROB. Commit and discard from the ROB resolve each entry.

---
 rtl/store_buffer_queue.sv | 158 +++++++++++++++
 tb/tb_store_buffer_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_queue.sv
// -----------------------------------------------------------------------------
// store_buffer_queue
//
// Store buffer for the MEM stage. Speculative word stores are held in a
// circular queue until the ROB commits or discards them. Committed stores
// drain to the data cache strictly in order. Younger loads can take their data
// from any live (pending or committed) entry.
//
// Ports
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   addr_i, data_i             store address/data on push; load address on lookup
//   load_i                     enables the forwarding lookup this cycle
//   bypass_o, data_rd_o        forwarding hit and forwarded data (0 on miss)
//   req_valid_i, req_ready_o   store push handshake
//   store_buffer_idx_o         entry index a push in this cycle receives
//   rsp_valid_o, rsp_ready_i   cache write handshake for the head entry
//   addr_o, data_wr_o          head entry address/data
//   store_buffer_commit_i,
//   store_buffer_idx_commit_i  ROB commit of one entry
//   store_buffer_discard_i     per-entry kill mask on flush
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready_o depends only on registered occupancy. rsp_valid_o,
// addr_o and data_wr_o depend only on registered state, so they hold steady
// while rsp_ready_i is 0.
// -----------------------------------------------------------------------------
module store_buffer_queue #(
   parameter int STORE_BUFFER_SIZE = 8,
   parameter int IDX_W             = $clog2(STORE_BUFFER_SIZE)
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [31:0]                  addr_i,
   input  logic [31:0]                  data_i,
   input  logic                         load_i,
   output logic                         bypass_o,
   output logic [31:0]                  data_rd_o,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   output logic [IDX_W-1:0]             store_buffer_idx_o,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [31:0]                  addr_o,
   output logic [31:0]                  data_wr_o,
   input  logic                         store_buffer_commit_i,
   input  logic [IDX_W-1:0]             store_buffer_idx_commit_i,
   input  logic [STORE_BUFFER_SIZE-1:0] store_buffer_discard_i
);

   typedef enum logic [1:0] {
      ST_FREE      = 2'd0,
      ST_PENDING   = 2'd1,
      ST_COMMITTED = 2'd2,
      ST_KILLED    = 2'd3
   } entry_state_t;

   localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(STORE_BUFFER_SIZE);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   entry_state_t      state_q [STORE_BUFFER_SIZE];
   entry_state_t      state_d [STORE_BUFFER_SIZE];
   logic [31:0]       addr_q  [STORE_BUFFER_SIZE];
   logic [31:0]       data_q  [STORE_BUFFER_SIZE];
   logic [IDX_W-1:0]  head_q;
   logic [IDX_W-1:0]  tail_q;
   logic [IDX_W:0]    count_q;

   logic              push;
   logic              pop_drain;
   logic              pop_skip;
   logic              pop;
   logic [IDX_W-1:0]  scan_idx;

   assign req_ready_o        = (count_q != FULL_CNT);
   assign store_buffer_idx_o = tail_q;
   assign push               = req_valid_i && req_ready_o;

   assign rsp_valid_o = (state_q[head_q] == ST_COMMITTED);
   assign addr_o      = addr_q[head_q];
   assign data_wr_o   = data_q[head_q];

   // A killed head is retired without a cache write, one entry per cycle.
   assign pop_drain = rsp_valid_o && rsp_ready_i;
   assign pop_skip  = (state_q[head_q] == ST_KILLED);
   assign pop       = pop_drain || pop_skip;

   // Entry state next-value logic. Discard is applied before commit so that a
   // commit and a discard aimed at the same entry leave it committed. Pop and
   // push can never land on the same entry: when head == tail the buffer is
   // either empty (head is FREE, no pop) or full (no push).
   always_comb begin
      state_d = state_q;
      for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
         if (store_buffer_discard_i[i] && (state_q[i] == ST_PENDING)) begin
            state_d[i] = ST_KILLED;
         end
      end
      if (store_buffer_commit_i &&
          (state_q[store_buffer_idx_commit_i] == ST_PENDING)) begin
         state_d[store_buffer_idx_commit_i] = ST_COMMITTED;
      end
      if (pop) begin
         state_d[head_q] = ST_FREE;
      end
      if (push) begin
         state_d[tail_q] = ST_PENDING;
      end
   end

   // Forwarding: walk entries oldest (head) to youngest so the last live match
   // wins, giving the youngest store. The head being drained is still live.
   always_comb begin
      bypass_o  = 1'b0;
      data_rd_o = '0;
      scan_idx  = head_q;
      for (int k = 0; k < STORE_BUFFER_SIZE; k++) begin
         scan_idx = head_q + IDX_W'(k);
         if (load_i && (addr_q[scan_idx] == addr_i) &&
             ((state_q[scan_idx] == ST_PENDING) ||
              (state_q[scan_idx] == ST_COMMITTED))) begin
            bypass_o  = 1'b1;
            data_rd_o = data_q[scan_idx];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            state_q[i] <= ST_FREE;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            state_q[i] <= state_d[i];
         end
         if (push) begin
            addr_q[tail_q] <= addr_i;
            data_q[tail_q] <= data_i;
            tail_q         <= tail_q + IDX_ONE;
         end
         if (pop) begin
            head_q <= head_q + IDX_ONE;
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_q <= count_q - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer_queue.sv
// -----------------------------------------------------------------------------
// tb_store_buffer_queue
//
// Directed testbench for store_buffer_queue (8 entries). Inputs are driven
// 1 ns after the rising edge and outputs are sampled in the same half cycle.
// Each test task resets the DUT, drives its scenario and compares inline.
// -----------------------------------------------------------------------------
module tb_store_buffer_queue;

   localparam int SIZE  = 8;
   localparam int IDX_W = 3;

   logic              clk;
   logic              rst_n;
   logic [31:0]       addr;
   logic [31:0]       data;
   logic              load;
   logic              bypass;
   logic [31:0]       data_rd;
   logic              req_valid;
   logic              req_ready;
   logic [IDX_W-1:0]  sb_idx;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       addr_out;
   logic [31:0]       data_wr;
   logic              commit;
   logic [IDX_W-1:0]  commit_idx;
   logic [SIZE-1:0]   discard;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   store_buffer_queue #(.STORE_BUFFER_SIZE(SIZE)) dut (
      .clk_i                     (clk),
      .rstn_i                    (rst_n),
      .addr_i                    (addr),
      .data_i                    (data),
      .load_i                    (load),
      .bypass_o                  (bypass),
      .data_rd_o                 (data_rd),
      .req_valid_i               (req_valid),
      .req_ready_o               (req_ready),
      .store_buffer_idx_o        (sb_idx),
      .rsp_valid_o               (rsp_valid),
      .rsp_ready_i               (rsp_ready),
      .addr_o                    (addr_out),
      .data_wr_o                 (data_wr),
      .store_buffer_commit_i     (commit),
      .store_buffer_idx_commit_i (commit_idx),
      .store_buffer_discard_i    (discard)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      addr       = '0;
      data       = '0;
      load       = 1'b0;
      req_valid  = 1'b0;
      rsp_ready  = 1'b0;
      commit     = 1'b0;
      commit_idx = '0;
      discard    = '0;
   endtask

   task automatic apply_reset();
      cycle();
      rst_n = 1'b0;
      idle();
      cycle();
      rst_n = 1'b1;
   endtask

   // ---------------- drivers ----------------
   task automatic push(input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      addr      = a;
      data      = d;
      cycle();
      req_valid = 1'b0;
   endtask

   task automatic do_commit(input logic [IDX_W-1:0] idx);
      commit     = 1'b1;
      commit_idx = idx;
      cycle();
      commit     = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      load = 1'b1;
      addr = 32'h0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b exp 0", rsp_valid); end
      checks++; if (bypass !== 1'b0) begin errors++; $display("FAIL rst_bypass got %0b exp 0", bypass); end
      checks++; if (data_rd !== 32'h0) begin errors++; $display("FAIL rst_data_rd got %h exp 0", data_rd); end
      checks++; if (addr_out !== 32'h0) begin errors++; $display("FAIL rst_addr_o got %h exp 0", addr_out); end
      checks++; if (data_wr !== 32'h0) begin errors++; $display("FAIL rst_data_wr got %h exp 0", data_wr); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0b exp 1", req_ready); end
      checks++; if (sb_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", sb_idx); end
      load = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_rsp_valid got %0b exp 0", rsp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_req_ready got %0b exp 1", req_ready); end
   endtask

   task automatic test_push_commit_drain();
      apply_reset();
      req_valid = 1'b1;
      addr      = 32'h100;
      data      = 32'hDEADBEEF;
      #1;
      checks++; if (sb_idx !== 3'd0) begin errors++; $display("FAIL pcd_idx got %0d exp 0", sb_idx); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL pcd_ready got %0b exp 1", req_ready); end
      cycle();
      req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pcd_pending_blocks got %0b exp 0", rsp_valid); end
      checks++; if (sb_idx !== 3'd1) begin errors++; $display("FAIL pcd_idx_after got %0d exp 1", sb_idx); end
      do_commit(3'd0);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pcd_rsp_valid got %0b exp 1", rsp_valid); end
      checks++; if (addr_out !== 32'h100) begin errors++; $display("FAIL pcd_addr_o got %h exp 00000100", addr_out); end
      checks++; if (data_wr !== 32'hDEADBEEF) begin errors++; $display("FAIL pcd_data_wr got %h exp deadbeef", data_wr); end
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pcd_drained got %0b exp 0", rsp_valid); end
      load = 1'b1;
      addr = 32'h100;
      #1;
      checks++; if (bypass !== 1'b0) begin errors++; $display("FAIL pcd_freed_no_fwd got %0b exp 0", bypass); end
      load = 1'b0;
   endtask

   task automatic test_forwarding();
      apply_reset();
      push(32'h200, 32'h11);
      push(32'h200, 32'h22);
      load = 1'b1;
      addr = 32'h200;
      #1;
      checks++; if (bypass !== 1'b1) begin errors++; $display("FAIL fwd_hit got %0b exp 1", bypass); end
      checks++; if (data_rd !== 32'h22) begin errors++; $display("FAIL fwd_youngest got %h exp 00000022", data_rd); end
      addr = 32'h204;
      #1;
      checks++; if (bypass !== 1'b0) begin errors++; $display("FAIL fwd_miss got %0b exp 0", bypass); end
      checks++; if (data_rd !== 32'h0) begin errors++; $display("FAIL fwd_miss_data got %h exp 0", data_rd); end
      load = 1'b0;
      addr = 32'h200;
      #1;
      checks++; if (bypass !== 1'b0) begin errors++; $display("FAIL fwd_no_load got %0b exp 0", bypass); end
      checks++; if (data_rd !== 32'h0) begin errors++; $display("FAIL fwd_no_load_data got %h exp 0", data_rd); end
      // Commit the older one, kill the younger: forwarding falls back to idx 0.
      do_commit(3'd0);
      discard = 8'h02;
      cycle();
      discard = '0;
      load = 1'b1;
      addr = 32'h200;
      #1;
      checks++; if (bypass !== 1'b1) begin errors++; $display("FAIL fwd_committed_hit got %0b exp 1", bypass); end
      checks++; if (data_rd !== 32'h11) begin errors++; $display("FAIL fwd_skip_killed got %h exp 00000011", data_rd); end
      load = 1'b0;
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < SIZE; i++) begin
         req_valid = 1'b1;
         addr      = 32'h1000 + 32'(i * 4);
         data      = 32'h50 + 32'(i);
         #1;
         checks++; if (sb_idx !== 3'(i)) begin errors++; $display("FAIL full_idx got %0d exp %0d", sb_idx, i); end
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_fill got %0b exp 1 at %0d", req_ready, i); end
         cycle();
      end
      req_valid = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready got %0b exp 0", req_ready); end
      checks++; if (sb_idx !== 3'd0) begin errors++; $display("FAIL full_idx_wrap got %0d exp 0", sb_idx); end
      // A push attempt while full is dropped.
      push(32'hBAD0, 32'hBAD);
      load = 1'b1;
      addr = 32'hBAD0;
      #1;
      checks++; if (bypass !== 1'b0) begin errors++; $display("FAIL full_push_dropped got %0b exp 0", bypass); end
      load = 1'b0;
      do_commit(3'd0);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL full_rsp_valid got %0b exp 1", rsp_valid); end
      checks++; if (addr_out !== 32'h1000) begin errors++; $display("FAIL full_head_addr got %h exp 00001000", addr_out); end
      // Head being drained this cycle is still forwardable; push in the pop cycle is refused.
      load      = 1'b1;
      addr      = 32'h1000;
      rsp_ready = 1'b1;
      #1;
      checks++; if (bypass !== 1'b1) begin errors++; $display("FAIL full_fwd_draining got %0b exp 1", bypass); end
      checks++; if (data_rd !== 32'h50) begin errors++; $display("FAIL full_fwd_draining_data got %h exp 00000050", data_rd); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_in_pop got %0b exp 0", req_ready); end
      load      = 1'b0;
      req_valid = 1'b1;
      addr      = 32'hBAD4;
      cycle();
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %0b exp 1", req_ready); end
      checks++; if (sb_idx !== 3'd0) begin errors++; $display("FAIL full_idx_after_pop got %0d exp 0", sb_idx); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL full_next_pending got %0b exp 0", rsp_valid); end
      push(32'h2000, 32'h77);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_refill got %0b exp 0", req_ready); end
   endtask

   task automatic test_discard();
      apply_reset();
      push(32'h10, 32'hA0);
      push(32'h14, 32'hA1);
      push(32'h18, 32'hA2);
      commit     = 1'b1;
      commit_idx = 3'd0;
      discard    = 8'h06;
      cycle();
      commit  = 1'b0;
      discard = '0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dis_rsp_valid got %0b exp 1", rsp_valid); end
      checks++; if (addr_out !== 32'h10) begin errors++; $display("FAIL dis_addr_o got %h exp 00000010", addr_out); end
      checks++; if (data_wr !== 32'hA0) begin errors++; $display("FAIL dis_data_wr got %h exp 000000a0", data_wr); end
      load = 1'b1;
      addr = 32'h14;
      #1;
      checks++; if (bypass !== 1'b0) begin errors++; $display("FAIL dis_killed_no_fwd got %0b exp 0", bypass); end
      checks++; if (data_rd !== 32'h0) begin errors++; $display("FAIL dis_killed_data got %h exp 0", data_rd); end
      addr = 32'h10;
      #1;
      checks++; if (data_rd !== 32'hA0) begin errors++; $display("FAIL dis_live_fwd got %h exp 000000a0", data_rd); end
      load = 1'b0;
      // Drain idx 0 while committing killed idx 1, which must be ignored.
      rsp_ready  = 1'b1;
      commit     = 1'b1;
      commit_idx = 3'd1;
      cycle();
      rsp_ready = 1'b0;
      commit    = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dis_skip1 got %0b exp 0", rsp_valid); end
      cycle();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dis_skip2 got %0b exp 0", rsp_valid); end
      cycle();
      checks++; if (sb_idx !== 3'd3) begin errors++; $display("FAIL dis_idx got %0d exp 3", sb_idx); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL dis_ready got %0b exp 1", req_ready); end
      push(32'h1C, 32'hB3);
      do_commit(3'd3);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dis_new_head got %0b exp 1", rsp_valid); end
      checks++; if (addr_out !== 32'h1C) begin errors++; $display("FAIL dis_new_addr got %h exp 0000001c", addr_out); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      push(32'h40, 32'h5555AAAA);
      do_commit(3'd0);
      for (int i = 0; i < 5; i++) begin
         req_valid = (i == 1);
         addr      = 32'h44;
         data      = 32'h1;
         #1;
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b exp 1 cyc %0d", rsp_valid, i); end
         checks++; if (addr_out !== 32'h40) begin errors++; $display("FAIL bp_addr got %h exp 00000040 cyc %0d", addr_out, i); end
         checks++; if (data_wr !== 32'h5555AAAA) begin errors++; $display("FAIL bp_data got %h exp 5555aaaa cyc %0d", data_wr, i); end
         cycle();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_drain got %0b exp 0", rsp_valid); end
      do_commit(3'd1);
      checks++; if (addr_out !== 32'h44) begin errors++; $display("FAIL bp_next_addr got %h exp 00000044", addr_out); end
   endtask

   task automatic test_back_to_back();
      logic [IDX_W-1:0] exp_idx;
      logic [31:0]      exp_addr;
      logic [31:0]      exp_data;
      apply_reset();
      exp_idx = '0;
      // Three rounds of three stores; the third round wraps the pointers.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (sb_idx !== exp_idx) begin errors++; $display("FAIL b2b_idx got %0d exp %0d", sb_idx, exp_idx); end
            exp_addr = 32'h3000 + 32'((r * 3 + i) * 4);
            exp_q.push_back(exp_addr);
            push(exp_addr, exp_addr ^ 32'hFFFF0000);
            exp_idx = exp_idx + 3'd1;
         end
         for (int i = 0; i < 3; i++) begin
            do_commit(exp_idx - 3'd3 + 3'(i));
         end
         rsp_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            exp_addr = exp_q.pop_front();
            exp_data = exp_addr ^ 32'hFFFF0000;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b exp 1", rsp_valid); end
            checks++; if (addr_out !== exp_addr) begin errors++; $display("FAIL b2b_addr got %h exp %h", addr_out, exp_addr); end
            checks++; if (data_wr !== exp_data) begin errors++; $display("FAIL b2b_data got %h exp %h", data_wr, exp_data); end
            cycle();
         end
         rsp_ready = 1'b0;
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", rsp_valid); end
      end
   endtask

   task automatic test_conflict_reset();
      apply_reset();
      push(32'h80, 32'hC0C0);
      commit     = 1'b1;
      commit_idx = 3'd0;
      discard    = 8'h01;
      cycle();
      commit  = 1'b0;
      discard = '0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cfl_commit_wins got %0b exp 1", rsp_valid); end
      checks++; if (data_wr !== 32'hC0C0) begin errors++; $display("FAIL cfl_data got %h exp 0000c0c0", data_wr); end
      discard = 8'h01;
      cycle();
      discard = '0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cfl_discard_committed got %0b exp 1", rsp_valid); end
      push(32'h84, 32'h1);
      rsp_ready = 1'b1;
      load      = 1'b1;
      addr      = 32'h84;
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cfl_rst_valid got %0b exp 0", rsp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL cfl_rst_ready got %0b exp 1", req_ready); end
      checks++; if (sb_idx !== 3'd0) begin errors++; $display("FAIL cfl_rst_idx got %0d exp 0", sb_idx); end
      checks++; if (addr_out !== 32'h0) begin errors++; $display("FAIL cfl_rst_addr got %h exp 0", addr_out); end
      checks++; if (bypass !== 1'b0) begin errors++; $display("FAIL cfl_rst_bypass got %0b exp 0", bypass); end
      idle();
      cycle();
      rst_n = 1'b1;
      cycle();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cfl_post_rst got %0b exp 0", rsp_valid); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b1;
      idle();
      #1;
      rst_n = 1'b0;
      test_reset();
      test_push_commit_drain();
      test_forwarding();
      test_full();
      test_discard();
      test_backpressure();
      test_back_to_back();
      test_conflict_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
